mem_fill_arbiter: RTL

Arbitrates instruction-cache and data-cache line-fill misses onto the single Sysbus read path, one 64-byte line at a time. Issues the line-aligned read request, collects eight 64-bit response beats into a 512-bit line, and returns it with a bit-offset progress counter and a per-requester completion pulse. Sits between the L1 caches and the top-level bus interface.

---
 rtl/mem_fill_arb_pkg.sv | 14 +
 rtl/mem_fill_arbiter_fill_line_assembler.sv | 33 +++
 rtl/mem_fill_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_fill_arb_pkg.sv
// mem_fill_arb_pkg: shared types and constants for the cache line-fill arbiter.
package mem_fill_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} fill_state_e;
    typedef enum logic {REQ_IC, REQ_DC} req_id_e;
    localparam int LINE_BITS = 512;
    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_BITS = 64;
    localparam logic [63:0] LINE_ALIGN_MASK = ~64'(LINE_BITS / 8 - 1);
    // Sysbus tag: READ flag, MEMORY target, zero sub-tag
    localparam logic [12:0] BUS_READ_TAG = {1'b1, 4'b0001, 8'h00};
    function automatic logic [63:0] line_align(input logic [63:0] a);
        return a & LINE_ALIGN_MASK;
    endfunction
endpackage

// File: rtl/mem_fill_arbiter_fill_line_assembler.sv
// fill_line_assembler: gathers response beats into a cache line with a bit-offset progress counter.
module fill_line_assembler
    import mem_fill_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 beat_valid,
    input  logic [BEAT_BITS-1:0] beat_data,
    output logic [LINE_BITS-1:0] fill_data,
    output logic [9:0]           fill_offset,
    output logic                 last_beat
);
    logic [2:0] beat_cnt;

    assign last_beat = beat_valid && beat_cnt == 3'(BEATS_PER_LINE - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_data   <= '0;
            fill_offset <= '0;
            beat_cnt    <= '0;
        end else if (clear) begin
            fill_data   <= '0;
            fill_offset <= '0;
            beat_cnt    <= '0;
        end else if (beat_valid) begin
            fill_data[{beat_cnt, 6'b0} +: BEAT_BITS] <= beat_data;
            fill_offset <= fill_offset + 10'(BEAT_BITS);
            beat_cnt    <= beat_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: arbitrates icache/dcache line fills onto the Sysbus read path.
// MEM_FILL_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise dcache has fixed priority.
module mem_fill_arbiter
    import mem_fill_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BITS      = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req,
    input  logic [BUS_DATA_WIDTH-1:0] ic_addr,
    input  logic                      dc_req,
    input  logic [BUS_DATA_WIDTH-1:0] dc_addr,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic [LINE_BITS-1:0]      fill_data,
    output logic [9:0]                fill_offset,
    output logic                      ic_fill_done,
    output logic                      dc_fill_done,
    output logic                      busy
);
    fill_state_e               state, state_nx;
    req_id_e                   id_q;
    logic [BUS_DATA_WIDTH-1:0] addr_q;
    logic                      clear, last_beat, pick_dc;

`ifdef MEM_FILL_ARB_ROUND_ROBIN_EN
    req_id_e last_grant;
    assign pick_dc = dc_req && (!ic_req || last_grant == REQ_IC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= REQ_DC;
        else if (clear)
            last_grant <= pick_dc ? REQ_DC : REQ_IC;
    end
`else
    assign pick_dc = dc_req;
`endif

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                clear    = ic_req || dc_req;
                state_nx = clear ? REQ : IDLE;
            end
            REQ:  state_nx = bus_reqack ? RESP : REQ;
            RESP: state_nx = last_beat ? DONE : RESP;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            addr_q <= '0;
            id_q   <= REQ_IC;
        end else begin
            state <= state_nx;
            if (clear) begin
                addr_q <= line_align(pick_dc ? dc_addr : ic_addr);
                id_q   <= pick_dc ? REQ_DC : REQ_IC;
            end
        end
    end

    assign bus_reqcyc   = state == REQ;
    assign bus_req      = bus_reqcyc ? addr_q : '0;
    assign bus_reqtag   = bus_reqcyc ? BUS_READ_TAG : '0;
    assign bus_respack  = state == RESP && bus_respcyc;
    assign ic_fill_done = state == DONE && id_q == REQ_IC;
    assign dc_fill_done = state == DONE && id_q == REQ_DC;
    assign busy         = state != IDLE;

    fill_line_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .beat_valid  (bus_respack),
        .beat_data   (bus_resp),
        .fill_data   (fill_data),
        .fill_offset (fill_offset),
        .last_beat   (last_beat)
    );
endmodule
